// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared constants and word layout for the DTW sample packer
package dtw_pkg;
  localparam int SAMPLE_W    = 10;
  localparam int PACK        = 3;
  localparam int MAX_WORDS   = 32;
  localparam int WORD_W      = 32;
  localparam int LAST_BIT    = 31;
  localparam int WORD_DATA_W = 30;

  // [31] last, [30] reserved zero, [29:0] samples packed LSB-first
  typedef struct packed {
    logic                   last;
    logic                   rsvd;
    logic [WORD_DATA_W-1:0] samples;
  } dtw_word_t;
endpackage

// File: rtl/dtw_word_fifo.sv
// rtl/dtw_word_fifo.sv - synchronous first-word-fall-through word FIFO
module dtw_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push = push_i && (count_q < CNT_W'(DEPTH));
    do_pop  = pop_i && (count_q != '0);
    wr_d    = wr_q + PTR_W'(do_push);
    rd_d    = rd_q + PTR_W'(do_pop);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the count is zero
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_q] : '0;
endmodule

// File: rtl/dtw_sample_packer.sv
// rtl/dtw_sample_packer.sv - packs reference samples into tagged 32-bit words
module dtw_sample_packer #(
  parameter int SAMPLE_W  = dtw_pkg::SAMPLE_W,
  parameter int PACK      = dtw_pkg::PACK,
  parameter int DEPTH     = 4,
  parameter int MAX_WORDS = dtw_pkg::MAX_WORDS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] s_data_i,
  input  logic                s_valid_i,
  input  logic                s_last_i,
  output logic                s_ready_o,
  output logic [31:0]         m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [5:0]          frame_words_o,
  output logic                trunc_o
);
  import dtw_pkg::*;

  localparam int DATA_W = SAMPLE_W * PACK;
  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] acc_q, acc_d, merged;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [5:0]        frame_q, frame_d, word_num;
  logic              trunc_q, trunc_d;
  logic              accept, push, pop;
  logic [CNT_W-1:0]  fifo_count;
  dtw_word_t         word;

  assign s_ready_o = !rst_i && (fifo_count < CNT_W'(DEPTH));
  assign accept    = s_valid_i && s_ready_o;
  assign m_valid_o = (fifo_count != '0);
  assign pop       = m_valid_o && m_ready_i;

  always_comb begin
    acc_d    = acc_q;
    slot_d   = slot_q;
    frame_d  = frame_q;
    trunc_d  = 1'b0;
    push     = 1'b0;
    word     = '0;
    merged   = acc_q | (DATA_W'(s_data_i) << (int'(slot_q) * SAMPLE_W));
    word_num = frame_q + 6'd1;
    if (accept) begin
      if (s_last_i || slot_q == SLOT_W'(PACK - 1)) begin
        push         = 1'b1;
        acc_d        = '0;
        slot_d       = '0;
        word.samples = WORD_DATA_W'(merged);
        // A full-length sequence without a last marker is closed here
        if (s_last_i || word_num == 6'(MAX_WORDS)) begin
          word.last = 1'b1;
          frame_d   = '0;
          trunc_d   = !s_last_i;
        end else begin
          frame_d = word_num;
        end
      end else begin
        acc_d  = merged;
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      slot_q  <= '0;
      frame_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
      trunc_q <= trunc_d;
    end
  end

  dtw_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (word),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (m_data_o)
  );

  assign frame_words_o = frame_q;
  assign trunc_o       = trunc_q;
endmodule

// File: tb/tb_dtw_sample_packer.sv
// tb/tb_dtw_sample_packer.sv - self-checking bench for dtw_sample_packer
module tb_dtw_sample_packer;
  localparam int SAMPLE_W  = 10;
  localparam int PACK      = 3;
  localparam int DEPTH     = 4;
  localparam int MAX_WORDS = 32;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic [SAMPLE_W-1:0] s_data_i = '0;
  logic                s_valid_i = 1'b0;
  logic                s_last_i = 1'b0;
  logic                s_ready_o;
  logic [31:0]         m_data_o;
  logic                m_valid_o;
  logic                m_ready_i = 1'b0;
  logic [5:0]          frame_words_o;
  logic                trunc_o;

  dtw_sample_packer #(
    .SAMPLE_W (SAMPLE_W),
    .PACK     (PACK),
    .DEPTH    (DEPTH),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_last_i     (s_last_i),
    .s_ready_o    (s_ready_o),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .frame_words_o(frame_words_o),
    .trunc_o      (trunc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: sequences of samples become words by plain arithmetic
  logic [31:0]         q[$];
  logic [SAMPLE_W-1:0] cur[$];
  logic [31:0]         pop_log[$];
  int                  m_fw = 0;
  bit                  m_trunc = 0;
  bit                  last_acc = 0;
  int                  trunc_seen = 0;

  typedef struct {
    bit                  rst;
    bit                  v;
    logic [SAMPLE_W-1:0] d;
    bit                  l;
    bit                  mr;
    bit                  e_sr;
    bit                  e_mv;
    logic [31:0]         e_md;
    logic [5:0]          e_fw;
    bit                  e_tr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [SAMPLE_W-1:0] d, input bit l);
    logic [31:0] w;
    cur.push_back(d);
    if (l || cur.size() == PACK) begin
      w = 0;
      foreach (cur[k]) w = w + (32'(cur[k]) << (k * SAMPLE_W));
      m_fw++;
      if (l || m_fw == MAX_WORDS) begin
        w[31]   = 1'b1;
        m_trunc = !l;
        m_fw    = 0;
      end
      q.push_back(w);
      cur.delete();
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [SAMPLE_W-1:0] d,
                      input bit l, input bit mr);
    bit          exp_sr;
    bit          pop;
    logic [31:0] exp_md;
    @(negedge clk_i);
    rst_i = rst; s_valid_i = v; s_data_i = d; s_last_i = l; m_ready_i = mr;
    #1;
    exp_sr = !rst && (q.size() < DEPTH);
    exp_md = (q.size() != 0) ? q[0] : 32'h0;
    chk("s_ready", 32'(s_ready_o), 32'(exp_sr));
    chk("m_valid", 32'(m_valid_o), 32'(q.size() != 0));
    chk("m_data", m_data_o, exp_md);
    chk("frame_words", 32'(frame_words_o), 32'(m_fw));
    chk("trunc", 32'(trunc_o), 32'(m_trunc));
    if (trunc_o === 1'b1) trunc_seen++;
    last_acc = v && exp_sr;
    pop      = mr && (q.size() != 0);
    m_trunc  = 0;
    if (rst) begin
      q.delete(); cur.delete(); m_fw = 0; last_acc = 0;
    end else begin
      if (pop) pop_log.push_back(q.pop_front());
      if (last_acc) model_push(d, l);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    // rst v d l mr | s_ready m_valid m_data frame trunc (after the edge)
    tbl[0] = '{1, 0, 10'h000, 0, 0, 0, 0, 32'h0,          6'd0, 0};
    tbl[1] = '{0, 1, 10'h001, 0, 1, 1, 0, 32'h0,          6'd0, 0};
    tbl[2] = '{0, 1, 10'h002, 0, 1, 1, 0, 32'h0,          6'd0, 0};
    tbl[3] = '{0, 1, 10'h003, 1, 1, 1, 1, 32'h8030_0801,  6'd0, 0};
    tbl[4] = '{0, 1, 10'h3FF, 0, 1, 1, 0, 32'h0,          6'd0, 0};
    tbl[5] = '{0, 1, 10'h3FF, 0, 1, 1, 0, 32'h0,          6'd0, 0};
    tbl[6] = '{0, 1, 10'h3FF, 0, 1, 1, 1, 32'h3FFF_FFFF,  6'd1, 0};
    tbl[7] = '{0, 1, 10'h3FF, 1, 0, 1, 1, 32'h3FFF_FFFF,  6'd0, 0};
    tbl[8] = '{0, 0, 10'h000, 0, 1, 1, 1, 32'h8000_03FF,  6'd0, 0};
    tbl[9] = '{0, 0, 10'h000, 0, 1, 1, 0, 32'h0,          6'd0, 0};

    for (int i = 0; i <= 10; i++) begin
      @(negedge clk_i);
      #1;
      if (i > 0) begin
        chk($sformatf("tbl%0d_s_ready", i - 1), 32'(s_ready_o), 32'(tbl[i-1].e_sr));
        chk($sformatf("tbl%0d_m_valid", i - 1), 32'(m_valid_o), 32'(tbl[i-1].e_mv));
        chk($sformatf("tbl%0d_m_data", i - 1), m_data_o, tbl[i-1].e_md);
        chk($sformatf("tbl%0d_frame", i - 1), 32'(frame_words_o), 32'(tbl[i-1].e_fw));
        chk($sformatf("tbl%0d_trunc", i - 1), 32'(trunc_o), 32'(tbl[i-1].e_tr));
      end
      if (i < 10) begin
        rst_i = tbl[i].rst; s_valid_i = tbl[i].v; s_data_i = tbl[i].d;
        s_last_i = tbl[i].l; m_ready_i = tbl[i].mr;
      end
    end

    // Backpressure: FIFO fills after 12 samples, then drains in order
    step(1, 0, 0, 0, 0);
    pop_log.delete();
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      step(0, idx < 15, SAMPLE_W'(idx + 1), idx == 14, 0);
      if (last_acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd12);
    chk("bp_s_ready_low", 32'(s_ready_o), 32'd0);
    for (int c = 0; c < 60 && (idx < 15 || q.size() != 0); c++) begin
      step(0, idx < 15, SAMPLE_W'(idx + 1), idx == 14, 1);
      if (last_acc) idx++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd15);
    chk("bp_words_out", 32'(pop_log.size()), 32'd5);

    // Truncation after MAX_WORDS words without a last marker
    step(1, 0, 0, 0, 0);
    pop_log.delete();
    trunc_seen = 0;
    idx = 0;
    for (int i = 1; i <= 100; i++) begin
      step(0, 1, SAMPLE_W'(i), 0, 1);
      if (last_acc) idx++;
    end
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 1);
    chk("tr_accepted", 32'(idx), 32'd100);
    chk("tr_pulses", 32'(trunc_seen), 32'd1);
    chk("tr_frame_restart", 32'(frame_words_o), 32'd1);
    if (pop_log.size() >= 33) begin
      chk("tr_word32_last", 32'(pop_log[31][31]), 32'd1);
      chk("tr_word31_not_last", 32'(pop_log[30][31]), 32'd0);
      chk("tr_word33_not_last", 32'(pop_log[32][31]), 32'd0);
    end else begin
      chk("tr_word_count", 32'(pop_log.size()), 32'd33);
    end

    // Simultaneous push and pop with three words buffered
    step(1, 0, 0, 0, 0);
    pop_log.delete();
    for (int i = 1; i <= 11; i++) step(0, 1, SAMPLE_W'(i), 0, 0);
    step(0, 1, SAMPLE_W'(12), 0, 1);
    chk("pp_s_ready", 32'(s_ready_o), 32'd1);
    for (int i = 13; i <= 15; i++) step(0, 1, SAMPLE_W'(i), i == 15, 0);
    step(0, 0, 0, 0, 0);
    chk("pp_full_after_extra", 32'(s_ready_o), 32'd0);
    for (int c = 0; c < 10; c++) step(0, 0, 0, 0, 1);
    chk("pp_words_out", 32'(pop_log.size()), 32'd5);

    // Mid-sequence reset discards buffered and partial words
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, 1, SAMPLE_W'(i), 0, 0);
    step(1, 0, 0, 0, 0);
    pop_log.delete();
    step(0, 1, 10'h00A, 0, 1);
    chk("rs_m_valid", 32'(m_valid_o), 32'd0);
    step(0, 1, 10'h00B, 0, 1);
    step(0, 1, 10'h00C, 1, 1);
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 1);
    chk("rs_word_count", 32'(pop_log.size()), 32'd1);
    if (pop_log.size() > 0) chk("rs_word", pop_log[0], 32'h80C0_2C0A);

    // Randomized traffic against the reference model
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           SAMPLE_W'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
